config_loader: RTL

//   Streaming configuration writer for the fpga fabric: accepts a framed word

---
 rtl/config_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// Streaming configuration writer: validates a framed word stream (header, payload, XOR
// checksum) and writes each payload word to its fabric config slot, committing on success.
module config_loader #(
  parameter int          WORD_W    = 32,
  parameter int          NUM_WORDS = 33,
  parameter int          ADDR_W    = 6,
  parameter logic [15:0] MAGIC     = 16'hC0F1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [WORD_W-1:0] cfg_data,
  output logic              cfg_commit,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [15:0]       HDR_COUNT = 16'(NUM_WORDS);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [WORD_W-1:0] r_acc, w_acc_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [WORD_W-1:0] r_data, w_data_nxt;
  logic              r_commit, w_commit_nxt;
  logic              w_accept;
  logic              w_hdr_ok;

  // Ready, busy and the sticky status flags are pure decodes of the state register.
  assign in_ready   = (r_state == S_HEADER) || (r_state == S_LOAD) || (r_state == S_CHECK);
  assign busy       = in_ready;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERROR);
  assign w_accept   = in_valid & in_ready;
  assign w_hdr_ok   = (in_data[31:16] == MAGIC) && (in_data[15:0] == HDR_COUNT);

  assign cfg_we     = r_we;
  assign cfg_addr   = r_addr;
  assign cfg_data   = r_data;
  assign cfg_commit = r_commit;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_acc_nxt    = r_acc;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_commit_nxt = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (w_accept) begin
          if (w_hdr_ok) begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = '0;
            w_acc_nxt   = '0;
          end else begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = r_idx;
          w_data_nxt = in_data;
          w_acc_nxt  = r_acc ^ in_data;
          // The index stops at the last slot, so it can never wrap into slot 0.
          if (r_idx == LAST_IDX) w_state_nxt = S_CHECK;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_CHECK: begin
        if (w_accept) begin
          if (in_data == r_acc) begin
            w_state_nxt  = S_DONE;
            w_commit_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_acc    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_commit <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_acc    <= w_acc_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_commit <= w_commit_nxt;
    end
  end

endmodule
